// File: rtl/adc_clkgen.sv
// adc_clkgen: NUM_CLOCKS integer-divided clocks derived from refclk, each with
// programmable divide, high time and phase; shadow config applied on commit.

module adc_clkgen #(
   parameter  int NUM_CLOCKS  = 2,
   parameter  int DIV_W       = 16,
   parameter  int LOCK_CYCLES = 8,
   localparam int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [DIV_W-1:0]      cfg_div,
   input  logic [DIV_W-1:0]      cfg_high,
   input  logic [DIV_W-1:0]      cfg_phase,
   input  logic                  cfg_commit,
   input  logic                  run,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outclk_stb,
   output logic                  locked
);

   localparam int LC_W = $clog2(LOCK_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PHASE,
      S_RUN
   } state_t;

   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic [DIV_W-1:0] high;
      logic [DIV_W-1:0] phase;
   } ch_cfg_t;

   state_t                state;
   state_t                state_nx;
   ch_cfg_t               shadow [NUM_CLOCKS];
   ch_cfg_t               active [NUM_CLOCKS];
   logic                  run_q;
   logic                  commit_evt;
   logic                  load_go;
   logic                  gen_active;
   logic                  all_started;
   logic [NUM_CLOCKS-1:0] en;
   logic [NUM_CLOCKS-1:0] started;
   logic [NUM_CLOCKS-1:0] outclk_d;
   logic [LC_W-1:0]       lock_cnt;

   assign commit_evt = run & (cfg_commit | ~run_q);

   // run_q resets high so a run level already present at reset release is not an edge.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         run_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples values from before the edge, independent of block ordering.
         run_q <= run;
      end
   end

   // NOTE: the configuration arrays are reset explicitly; a reset must wipe
   // every shadow and active setting, so they cannot be left as plain RAM.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CLOCKS; i++) shadow[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_valid && cfg_ready && cfg_ch == CH_W'(i))
               shadow[i] <= {cfg_div, cfg_high, cfg_phase};
         end
      end
   end

   // Captured on the commit edge itself, so a same-cycle shadow write is not seen.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CLOCKS; i++) active[i] <= '0;
      end else if (load_go) begin
         active <= shadow;
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      state_nx = state;
      if (!run) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (commit_evt) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_PHASE;
            S_PHASE: begin
               if (commit_evt)       state_nx = S_LOAD;
               else if (all_started) state_nx = S_RUN;
            end
            S_RUN:   if (commit_evt) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cfg_ready  = (state != S_LOAD);
      gen_active = (state == S_PHASE) || (state == S_RUN);
      load_go    = (state_nx == S_LOAD);
   end

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] ph_cnt;

      assign en[g]       = active[g].div > DIV_W'(1);
      assign started[g]  = en[g] & gen_active & (ph_cnt == '0);
      assign outclk_d[g] = started[g] & (cnt < active[g].high);

      always_ff @(posedge refclk or negedge rst) begin
         if (!rst) begin
            cnt    <= '0;
            ph_cnt <= '0;
         end else if (state == S_LOAD) begin
            cnt    <= '0;
            ph_cnt <= active[g].phase;
         end else if (started[g]) begin
            cnt <= (cnt >= active[g].div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
         end else if (gen_active && ph_cnt != '0) begin
            ph_cnt <= ph_cnt - DIV_W'(1);
         end
      end
   end

   // Disabled channels never block the transition to RUN.
   assign all_started = &(started | ~en);

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         outclk     <= '0;
         outclk_stb <= '0;
      end else if (!run || load_go || state == S_LOAD) begin
         outclk     <= '0;
         outclk_stb <= '0;
      end else begin
         outclk     <= outclk_d;
         outclk_stb <= outclk_d & ~outclk;
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (!run || load_go || state != S_RUN) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         if (lock_cnt != LC_W'(LOCK_CYCLES)) lock_cnt <= lock_cnt + 1'b1;
         if (lock_cnt == LC_W'(LOCK_CYCLES - 1)) locked <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_clkgen.sv
// Directed bench for adc_clkgen (NUM_CLOCKS=2, DIV_W=16, LOCK_CYCLES=8);
// outputs are sampled on the falling edge of refclk.

module tb_adc_clkgen;

   logic        refclk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [0:0]  cfg_ch;
   logic [15:0] cfg_div;
   logic [15:0] cfg_high;
   logic [15:0] cfg_phase;
   logic        cfg_commit;
   logic        run;
   logic [1:0]  outclk;
   logic [1:0]  outclk_stb;
   logic        locked;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 refclk = ~refclk;

   adc_clkgen #(
      .NUM_CLOCKS (2),
      .DIV_W      (16),
      .LOCK_CYCLES(8)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .cfg_commit(cfg_commit),
      .run       (run),
      .outclk    (outclk),
      .outclk_stb(outclk_stb),
      .locked    (locked)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cfg_write(input int ch, input int div, input int high, input int phase);
      cfg_valid = 1'b1;
      cfg_ch    = 1'(ch);
      cfg_div   = 16'(div);
      cfg_high  = 16'(high);
      cfg_phase = 16'(phase);
      cyc(1);
      cfg_valid = 1'b0;
   endtask

   task automatic measure(input int n, output int hi0, output int hi1,
                          output int st0, output int st1, output int lk);
      hi0 = 0; hi1 = 0; st0 = 0; st1 = 0; lk = 0;
      repeat (n) begin
         cyc(1);
         hi0 += int'(outclk[0]);
         hi1 += int'(outclk[1]);
         st0 += int'(outclk_stb[0]);
         st1 += int'(outclk_stb[1]);
         lk  += int'(locked);
      end
   endtask

   initial begin
      int hi0, hi1, st0, st1, lk, bad;
      rst = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
      cfg_phase = '0; cfg_commit = 1'b0; run = 1'b0;

      // Reset values, then a long quiet idle
      cyc(2);
      check("rst_outclk", outclk, 0);
      check("rst_stb", outclk_stb, 0);
      check("rst_locked", locked, 0);
      check("rst_ready", cfg_ready, 1);
      rst = 1'b1;
      bad = 0;
      repeat (20) begin
         cyc(1);
         if (outclk != 0 || outclk_stb != 0 || locked || !cfg_ready) bad++;
      end
      check("idle_quiet", bad, 0);

      // ch0 25/12, ch1 4/2, started by a rising edge of run
      cfg_write(0, 25, 12, 0);
      cfg_write(1, 4, 2, 0);
      check("shadow_no_effect", outclk, 0);
      run = 1'b1;
      cyc(1);
      check("load_ready_low", cfg_ready, 0);
      check("load_outclk", outclk, 0);
      cyc(1);
      check("phase_outclk", outclk, 0);
      check("phase_ready", cfg_ready, 1);
      cyc(1);
      check("first_rise", outclk, 2'b11);
      check("first_stb", outclk_stb, 2'b11);
      cyc(7);
      check("lock_early", locked, 0);
      cyc(1);
      check("lock_on_time", locked, 1);
      measure(100, hi0, hi1, st0, st1, lk);
      check("a_hi0", hi0, 48);
      check("a_hi1", hi1, 50);
      check("a_stb0", st0, 4);
      check("a_stb1", st1, 25);
      check("a_locked", lk, 100);

      // Phase offset: ch1 rises 3 cycles after ch0
      cfg_write(0, 10, 5, 0);
      cfg_write(1, 10, 5, 3);
      cfg_commit = 1'b1;
      cyc(1);
      cfg_commit = 1'b0;
      check("b_lock_drop", locked, 0);
      check("b_load_outclk", outclk, 0);
      cyc(1);
      check("b_p1_outclk", outclk, 0);
      cyc(1);
      check("b_ch0_rise", outclk, 2'b01);
      check("b_ch0_stb", outclk_stb, 2'b01);
      cyc(2);
      check("b_ch1_wait", outclk, 2'b01);
      cyc(1);
      check("b_ch1_rise", outclk, 2'b11);
      check("b_ch1_stb", outclk_stb, 2'b10);
      cyc(7);
      check("b_lock_early", locked, 0);
      cyc(1);
      check("b_lock_on_time", locked, 1);

      // Uncommitted write leaves outputs alone
      cfg_write(0, 8, 4, 0);
      measure(100, hi0, hi1, st0, st1, lk);
      check("c_hi0", hi0, 50);
      check("c_stb0", st0, 10);
      check("c_stb1", st1, 10);
      check("c_locked", lk, 100);

      // Commit with a same-cycle ch1 write: ch1 keeps 10/5 phase 3
      cfg_commit = 1'b1;
      cfg_valid  = 1'b1;
      cfg_ch     = 1'b1;
      cfg_div    = 16'd6;
      cfg_high   = 16'd3;
      cfg_phase  = 16'd0;
      cyc(1);
      cfg_commit = 1'b0;
      cfg_valid  = 1'b0;
      check("d_lock_drop", locked, 0);
      cyc(13);
      check("d_relock", locked, 1);
      measure(80, hi0, hi1, st0, st1, lk);
      check("d_hi0", hi0, 40);
      check("d_stb0", st0, 10);
      check("d_hi1", hi1, 40);
      check("d_stb1", st1, 8);
      check("d_locked", lk, 80);

      // ch0 disabled (div=1), ch1 high>=div
      cfg_write(0, 1, 0, 0);
      cfg_write(1, 5, 7, 0);
      cfg_commit = 1'b1;
      cyc(1);
      cfg_commit = 1'b0;
      check("e_lock_drop", locked, 0);
      cyc(1);
      check("e_p1_outclk", outclk, 0);
      cyc(1);
      check("e_rise", outclk, 2'b10);
      check("e_stb", outclk_stb, 2'b10);
      cyc(7);
      check("e_lock_early", locked, 0);
      cyc(1);
      check("e_lock_on_time", locked, 1);
      measure(50, hi0, hi1, st0, st1, lk);
      check("e_hi0", hi0, 0);
      check("e_stb0", st0, 0);
      check("e_hi1", hi1, 50);
      check("e_stb1", st1, 0);
      check("e_locked", lk, 50);

      // Asynchronous reset between edges, run held high afterwards
      #2 rst = 1'b0;
      #1;
      check("f_async_outclk", outclk, 0);
      check("f_async_locked", locked, 0);
      check("f_async_ready", cfg_ready, 1);
      @(negedge refclk);
      rst = 1'b1;
      bad = 0;
      repeat (30) begin
         cyc(1);
         if (outclk != 0 || locked || !cfg_ready) bad++;
      end
      check("f_no_restart", bad, 0);

      // New run edge with shadows lost: all channels disabled, still locks
      run = 1'b0;
      cyc(1);
      run = 1'b1;
      cyc(10);
      check("g_lock_early", locked, 0);
      cyc(1);
      check("g_lock_on_time", locked, 1);
      check("g_outclk", outclk, 0);
      run = 1'b0;
      cyc(1);
      check("g_run_low_unlock", locked, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
